axi4lite_master_queued: RTL and testbench

Next-generation AXI4-Lite master for the testbench library. Accepts read and write commands into
//   a parametrised command FIFO, runs each one on the AXI4-Lite bus in order, one at a time, and returns one

---
 rtl/axi4lite_tb_pkg.sv | 26 ++
 rtl/axi4lite_cmd_fifo.sv | 55 +++++
 rtl/axi4lite_master_queued.sv | 196 +++++++++++++++++++
 tb/tb_axi4lite_master_queued.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_tb_pkg.sv
// Shared types and constants for the queued AXI4-Lite master: FSM states,
// AXI response codes and the timeout status value.
package axi4lite_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_AW_W,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_RESP
  } fsm_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_TIMEOUT  = 3'b100;

  // States in which a bus access is outstanding and the watchdog runs.
  function automatic logic is_active(input fsm_state_t s);
    return (s == S_WR_AW_W) || (s == S_WR_B) || (s == S_RD_AR) || (s == S_RD_R);
  endfunction

endpackage

// File: rtl/axi4lite_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO; power-of-two depth,
// pointers wrap naturally, occupancy counter one bit wider than the pointers.
module axi4lite_cmd_fifo #(
  parameter int G_WIDTH = 8,
  parameter int G_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [G_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic [G_WIDTH-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int PW = $clog2(G_DEPTH);
  localparam int CW = PW + 1;

  logic [G_WIDTH-1:0] mem [G_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_push;
  logic               do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(G_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and an un-reset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi4lite_master_queued.sv
// Queued AXI4-Lite master: commands are buffered in a FIFO and executed one at
// a time, in order, each producing a single response pulse; a watchdog aborts hung accesses.
module axi4lite_master_queued
  import axi4lite_tb_pkg::*;
#(
  parameter int G_AXI4LITE_ADDR_WIDTH = 32,
  parameter int G_AXI4LITE_DATA_WIDTH = 32,
  parameter int G_CMD_DEPTH           = 4,
  parameter int G_TIMEOUT             = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [G_AXI4LITE_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                               cmd_rnw,
  input  logic [G_AXI4LITE_DATA_WIDTH/8-1:0] cmd_strobe,
  input  logic [G_AXI4LITE_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                               rsp_valid,
  output logic [G_AXI4LITE_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [2:0]                         rsp_status,
  output logic [G_AXI4LITE_ADDR_WIDTH-1:0]   m_awaddr,
  output logic                               m_awvalid,
  input  logic                               m_awready,
  output logic [G_AXI4LITE_DATA_WIDTH-1:0]   m_wdata,
  output logic [G_AXI4LITE_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                               m_wvalid,
  input  logic                               m_wready,
  input  logic [1:0]                         m_bresp,
  input  logic                               m_bvalid,
  output logic                               m_bready,
  output logic [G_AXI4LITE_ADDR_WIDTH-1:0]   m_araddr,
  output logic                               m_arvalid,
  input  logic                               m_arready,
  input  logic [G_AXI4LITE_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                         m_rresp,
  input  logic                               m_rvalid,
  output logic                               m_rready
);

  localparam int AW    = G_AXI4LITE_ADDR_WIDTH;
  localparam int DW    = G_AXI4LITE_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int CMD_W = AW + 1 + SW + DW;
  localparam int WD_W  = (G_TIMEOUT > 2) ? $clog2(G_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (G_TIMEOUT > 0) ? WD_W'(G_TIMEOUT - 1) : '0;

  fsm_state_t      state_q, state_d;

  logic            cmd_ready_en_q;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_wr_data, fifo_rd_data;
  logic [AW-1:0]   c_addr;
  logic            c_rnw;
  logic [SW-1:0]   c_strb;
  logic [DW-1:0]   c_wdata;

  logic            aw_done_q, w_done_q;
  logic            aw_hs, w_hs;
  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_expired;

  logic [AW-1:0]   awaddr_q, araddr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      resp_q;
  logic            timeout_q;

  // cmd_ready stays low through reset and rises the cycle after rst drops.
  assign cmd_ready    = cmd_ready_en_q && !fifo_full;
  assign fifo_push    = cmd_valid && cmd_ready;
  assign fifo_wr_data = {cmd_addr, cmd_rnw, cmd_strobe, cmd_wdata};
  assign {c_addr, c_rnw, c_strb, c_wdata} = fifo_rd_data;

  axi4lite_cmd_fifo #(
    .G_WIDTH (CMD_W),
    .G_DEPTH (G_CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Handshakes derived from registered state so the FSM has no path from its own outputs.
  assign aw_hs      = (state_q == S_WR_AW_W) && !aw_done_q && m_awready;
  assign w_hs       = (state_q == S_WR_AW_W) && !w_done_q  && m_wready;
  assign wd_expired = (G_TIMEOUT != 0) && is_active(state_q) && (wd_cnt_q == WD_LAST);

  assign m_awaddr = awaddr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign m_araddr = araddr_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    m_awvalid = (state_q == S_WR_AW_W) && !aw_done_q;
    m_wvalid  = (state_q == S_WR_AW_W) && !w_done_q;
    m_bready  = (state_q == S_WR_B);
    m_arvalid = (state_q == S_RD_AR);
    m_rready  = (state_q == S_RD_R);

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = c_rnw ? S_RD_AR : S_WR_AW_W;
        end
      end
      S_WR_AW_W: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WR_B;
      end
      S_WR_B:  if (m_bvalid)  state_d = S_RESP;
      S_RD_AR: if (m_arready) state_d = S_RD_R;
      S_RD_R:  if (m_rvalid)  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wd_expired) state_d = S_RESP;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cmd_ready_en_q <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      wd_cnt_q       <= '0;
      awaddr_q       <= '0;
      araddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      rdata_q        <= '0;
      resp_q         <= RESP_OKAY;
      timeout_q      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_status     <= '0;
    end else begin
      state_q        <= state_d;
      cmd_ready_en_q <= 1'b1;

      if (fifo_pop) begin
        wd_cnt_q  <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        rdata_q   <= '0;
        resp_q    <= RESP_OKAY;
        timeout_q <= 1'b0;
        if (c_rnw) begin
          araddr_q <= c_addr;
        end else begin
          awaddr_q <= c_addr;
          wdata_q  <= c_wdata;
          wstrb_q  <= c_strb;
        end
      end else if (is_active(state_q)) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end

      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;

      if ((state_q == S_WR_B) && m_bvalid) resp_q <= m_bresp;
      if ((state_q == S_RD_R) && m_rvalid) begin
        rdata_q <= m_rdata;
        resp_q  <= m_rresp;
      end

      // An expiring watchdog overrides anything captured in the same cycle.
      if (wd_expired) begin
        timeout_q <= 1'b1;
        rdata_q   <= '0;
        resp_q    <= RESP_OKAY;
      end

      rsp_valid <= (state_q == S_RESP);
      if (state_q == S_RESP) begin
        rsp_rdata  <= rdata_q;
        rsp_status <= {timeout_q, resp_q};
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_master_queued.sv
// Self-checking bench for axi4lite_master_queued: a reactive AXI4-Lite slave
// model plus a scoreboard of expected responses filled as commands are accepted.
module tb_axi4lite_master_queued;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_rnw = 1'b0;
  logic [3:0]  cmd_strobe = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_status;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  axi4lite_master_queued #(
    .G_AXI4LITE_ADDR_WIDTH (32),
    .G_AXI4LITE_DATA_WIDTH (32),
    .G_CMD_DEPTH           (4),
    .G_TIMEOUT             (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_rnw    (cmd_rnw),
    .cmd_strobe (cmd_strobe),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_status (rsp_status),
    .m_awaddr   (m_awaddr),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready),
    .m_araddr   (m_araddr),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  status;
    int          push_cyc;
    int          exp_lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  // Slave knobs.
  int cfg_aw_delay = 0;
  int cfg_w_delay  = 0;
  bit cfg_stall    = 1'b0;
  bit cfg_ar_hang  = 1'b0;
  bit cfg_b_hold   = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // The slave answers according to address bits [13:12]: OKAY, EXOKAY, SLVERR, DECERR.
  function automatic logic [1:0] region_resp(input logic [31:0] addr);
    return addr[13:12];
  endfunction

  // Slave model: acts at negedge; a fire flag predicts the handshake on the next posedge.
  initial begin
    bit s_aw_fire = 0, s_w_fire = 0, s_ar_fire = 0, s_b_fire = 0, s_r_fire = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0;
    int aw_wait = 0, w_wait = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, old;
    logic [3:0]  s_wstrb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {s_aw_fire, s_w_fire, s_ar_fire, s_b_fire, s_r_fire} = '0;
        {aw_got, w_got, ar_got} = '0;
        aw_wait = 0;
        w_wait  = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid  = 0; m_rvalid = 0;
      end else begin
        if (s_aw_fire) aw_got = 1;
        if (s_w_fire)  w_got  = 1;
        if (s_ar_fire) ar_got = 1;
        if (s_b_fire)  m_bvalid = 0;
        if (s_r_fire)  m_rvalid = 0;

        m_awready = 0;
        if (m_awvalid && !cfg_stall) begin
          if (aw_wait >= cfg_aw_delay) begin
            m_awready = 1; s_awaddr = m_awaddr; aw_wait = 0;
          end else aw_wait++;
        end
        m_wready = 0;
        if (m_wvalid && !cfg_stall) begin
          if (w_wait >= cfg_w_delay) begin
            m_wready = 1; s_wdata = m_wdata; s_wstrb = m_wstrb; w_wait = 0;
          end else w_wait++;
        end
        m_arready = 0;
        if (m_arvalid && !cfg_stall && !cfg_ar_hang) begin
          m_arready = 1; s_araddr = m_araddr;
        end

        if (aw_got && w_got && !m_bvalid && !cfg_b_hold) begin
          old = slave_mem.exists(s_awaddr) ? slave_mem[s_awaddr] : 32'h0;
          slave_mem[s_awaddr] = merge(old, s_wdata, s_wstrb);
          m_bresp  = region_resp(s_awaddr);
          m_bvalid = 1;
          aw_got = 0; w_got = 0;
        end
        if (ar_got && !m_rvalid) begin
          m_rdata  = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : 32'h0;
          m_rresp  = region_resp(s_araddr);
          m_rvalid = 1;
          ar_got = 0;
        end

        s_aw_fire = m_awvalid && m_awready;
        s_w_fire  = m_wvalid  && m_wready;
        s_ar_fire = m_arvalid && m_arready;
        s_b_fire  = m_bvalid  && m_bready;
        s_r_fire  = m_rvalid  && m_rready;
      end
    end
  end

  // Response monitor and bus activity counters.
  int rsp_cnt = 0;
  int bready_rises = 0;
  int ar_run = 0;
  int last_ar_run = 0;
  int issue_cnt = 0;
  initial begin
    bit   prev_bready = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_bready && !prev_bready) bready_rises++;
        prev_bready = m_bready;
        if (m_arvalid) ar_run++;
        else if (ar_run != 0) begin
          last_ar_run = ar_run;
          ar_run = 0;
        end
        if (m_awvalid || m_arvalid) issue_cnt++;
        if (rsp_valid) begin
          rsp_cnt++;
          if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_status", 32'(rsp_status), 32'(e.status));
            if (e.exp_lat > 0) check("rsp_latency", 32'(cyc - e.push_cyc), 32'(e.exp_lat));
          end
        end
      end else prev_bready = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the command is accepted.
  task automatic push_cmd(input logic [31:0] addr, input logic rnw, input logic [3:0] strb,
                          input logic [31:0] wdata, input int exp_lat);
    int   waited = 0;
    exp_t e;
    logic [31:0] old;
    cmd_valid  = 1'b1;
    cmd_addr   = addr;
    cmd_rnw    = rnw;
    cmd_strobe = strb;
    cmd_wdata  = wdata;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("push_wait", 32'd0, 32'd1);
    end else begin
      e.push_cyc = cyc;
      e.exp_lat  = exp_lat;
      if (rnw) begin
        old      = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        e.rdata  = cfg_ar_hang ? 32'h0 : old;
        e.status = cfg_ar_hang ? 3'b100 : {1'b0, region_resp(addr)};
      end else begin
        old      = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        ref_mem[addr] = merge(old, wdata, strb);
        e.rdata  = 32'h0;
        e.status = {1'b0, region_resp(addr)};
      end
      sb.push_back(e);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int r0, b0, i0;
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, b0, i0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs",
          32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready}), 32'd0);
    check("reset_rsp_status", 32'(rsp_status), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Zero-wait write: AW and W together at N+2, response at N+5.
    push_cmd(32'h10, 1'b0, 4'hF, 32'hDEADBEEF, 5);
    check("no_issue_at_n1", 32'(m_awvalid || m_wvalid), 32'd0);
    @(negedge clk);
    check("aw_w_together", 32'({m_awvalid, m_wvalid}), 32'd3);
    check("awaddr", m_awaddr, 32'h10);
    check("wdata", m_wdata, 32'hDEADBEEF);
    check("wstrb", 32'(m_wstrb), 32'hF);
    drain();

    // Reads, all four response codes, partial strobes.
    push_cmd(32'h10,   1'b1, 4'h0, 32'h0, 5);
    push_cmd(32'h2010, 1'b1, 4'h0, 32'h0, 0);
    push_cmd(32'h1000, 1'b0, 4'hF, 32'hCAFEF00D, 0);
    push_cmd(32'h3000, 1'b0, 4'hF, 32'h12345678, 0);
    push_cmd(32'h20,   1'b0, 4'hF, 32'h11223344, 0);
    push_cmd(32'h20,   1'b0, 4'b0101, 32'hAABBCCDD, 0);
    push_cmd(32'h20,   1'b1, 4'h0, 32'h0, 0);
    push_cmd(32'h1000, 1'b1, 4'h0, 32'h0, 0);
    drain();

    // W before AW, then AW before W: one bready phase and one response each.
    cfg_aw_delay = 3; cfg_w_delay = 0;
    r0 = rsp_cnt; b0 = bready_rises;
    push_cmd(32'h40, 1'b0, 4'hF, 32'h0BADF00D, 0);
    drain();
    check("w_first_bready_phases", 32'(bready_rises - b0), 32'd1);
    check("w_first_responses", 32'(rsp_cnt - r0), 32'd1);
    cfg_aw_delay = 0; cfg_w_delay = 3;
    r0 = rsp_cnt; b0 = bready_rises;
    push_cmd(32'h44, 1'b0, 4'hF, 32'h600DCAFE, 0);
    drain();
    check("aw_first_bready_phases", 32'(bready_rises - b0), 32'd1);
    check("aw_first_responses", 32'(rsp_cnt - r0), 32'd1);
    cfg_w_delay = 0;
    push_cmd(32'h40, 1'b1, 4'h0, 32'h0, 0);
    push_cmd(32'h44, 1'b1, 4'h0, 32'h0, 0);
    drain();

    // Stalled slave: one command in flight plus four queued fills the FIFO.
    cfg_stall = 1'b1;
    r0 = rsp_cnt;
    push_cmd(32'h50, 1'b0, 4'hF, 32'hA5A5A5A5, 0);
    repeat (2) @(negedge clk);
    push_cmd(32'h50, 1'b1, 4'h0, 32'h0, 0);
    push_cmd(32'h54, 1'b0, 4'hF, 32'h5A5A5A5A, 0);
    push_cmd(32'h54, 1'b1, 4'h0, 32'h0, 0);
    push_cmd(32'h58, 1'b0, 4'h3, 32'hFFFF1234, 0);
    check("ready_low_when_full", 32'(cmd_ready), 32'd0);
    cfg_stall = 1'b0;
    drain();
    check("stall_responses", 32'(rsp_cnt - r0), 32'd5);

    // Hung read: watchdog drops arvalid after 16 cycles, then a normal write.
    cfg_ar_hang = 1'b1;
    push_cmd(32'h10, 1'b1, 4'h0, 32'h0, 19);
    drain();
    cfg_ar_hang = 1'b0;
    check("timeout_arvalid_cycles", 32'(last_ar_run), 32'd16);
    push_cmd(32'h60, 1'b0, 4'hF, 32'h0000BEEF, 5);
    drain();

    // Reset while in WR_B with two commands queued.
    cfg_b_hold = 1'b1;
    push_cmd(32'h70, 1'b0, 4'hF, 32'h77777777, 0);
    push_cmd(32'h70, 1'b1, 4'h0, 32'h0, 0);
    push_cmd(32'h74, 1'b0, 4'hF, 32'h74747474, 0);
    check("in_wr_b_before_reset", 32'(m_bready), 32'd1);
    rst = 1'b1;
    sb.delete();
    ref_mem.delete(32'h70);
    ref_mem.delete(32'h74);
    @(negedge clk);
    check("mid_reset_outputs",
          32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cfg_b_hold = 1'b0;
    r0 = rsp_cnt; i0 = issue_cnt;
    @(negedge clk);
    check("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
    repeat (12) @(negedge clk);
    check("no_replay_after_reset", 32'(issue_cnt - i0), 32'd0);
    check("no_rsp_after_reset", 32'(rsp_cnt - r0), 32'd0);

    push_cmd(32'h80, 1'b0, 4'hF, 32'h80808080, 5);
    push_cmd(32'h80, 1'b1, 4'h0, 32'h0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
